regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port register file with per-register scoreboard and a sequenced bulk-clear engine. It sits in the datapath between decode and the ALU and provides NR combinational read ports and one synchronous write port. It tracks which registers have a write pending (busy), and can be wiped to zero on request without asserting reset. Register 0 is hardwired to zero.

## Interface
- N, 5: address width; depth is 2**N registers.
- W, 32: data width of each register.
- NR, 2: number of read ports (1..4).
- clk  in  1: clock; all state updates on its rising edge.
- rst  in  1: reset; asynchronous, active-low. Clears all registers, all busy bits and the clear FSM.
- rd_addr  in  NR*N: packed read addresses; port k uses bits [k*N +: N].
- rd_data  out  NR*W: packed read data; port k uses bits [k*W +: W].
- rd_ready  out  NR: port k is 1 when its register is not busy.
- we  in  1: write enable.
- wr_addr  in  N: write address.
- wr_data  in  W: write data.
- alloc  in  1: marks register alloc_addr busy (a write is pending).
- alloc_addr  in  N: register to mark busy.
- clear_req  in  1: requests a bulk clear; sampled only in IDLE.
- clear_busy  out  1: high while a bulk clear is in progress.
- clear_done  out  1: one-cycle pulse when a bulk clear completes.

## Operation
- Storage: 2**N × W flops plus a 2**N busy vector. Reg 0 always reads 0 with ready 1. Writes and allocs to address 0 are ignored.
- Write: when we=1 and wr_addr≠0, the register is written and its busy bit is cleared at the edge.
- Alloc: when alloc=1 and alloc_addr≠0, the busy bit is set at the edge.
- Alloc and write to the same address in the same cycle: data is written and the busy bit ends at 1 (alloc wins).
- Read port k is combinational: rd_data_k = reg[rd_addr_k] and rd_ready_k = ~busy[rd_addr_k], subject to the bypass rules under Configuration.
- Clear FSM has two states, IDLE and CLEAR.
  - IDLE → CLEAR on clear_req=1. The clear counter loads 0 and clear_busy goes 1 in the next cycle.
  - In CLEAR, each cycle zeroes reg[cnt] and busy[cnt], then increments cnt.
  - When cnt = 2**N−1, that entry is cleared, the FSM returns to IDLE, and clear_done pulses for exactly one cycle (the cycle after the last clear).
  - Clear duration is 2**N cycles.
- During CLEAR:
  - we, alloc and clear_req are ignored.
  - Every read port returns rd_data=0 and rd_ready=0, except address 0, which returns data 0 and ready 1.
- Reset asserted mid-clear aborts it immediately. State returns to IDLE with the counter at 0, and clear_done is not pulsed.

## Timing
- Reset values: all registers 0, busy all 0, clear_busy 0, clear_done 0, rd_ready all 1, rd_data all 0.
- Read latency is 0 cycles (combinational from rd_addr and state).
- Write latency: data is visible on a read the cycle after the edge, or in the same cycle with bypass (see Configuration).
- Alloc: rd_ready drops in the cycle after the alloc edge.
- clear_req and clear_busy:
  - clear_req asserted in cycle t gives clear_busy=1 in cycles t+1 … t+2**N.
  - clear_done=1 in cycle t+2**N+1, with clear_busy=0 in that same cycle.
  - A write or alloc issued in cycle t itself (IDLE) still takes effect.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding is compiled in.
  - If we=1, wr_addr≠0, wr_addr=rd_addr_k and the FSM is IDLE, then rd_data_k=wr_data and rd_ready_k=1 in the same cycle, regardless of the busy bit.
  - This holds even if alloc targets the same address in that cycle.
- REGFILE_BYPASS_EN undefined: no forwarding. Read ports see only stored contents and the registered busy vector.

## Test plan
- Reset then read: assert rst=0 while addresses hold 1..31 → rd_data=0 and rd_ready=1 on all ports. After release, the same holds.
- Write and readback: we=1, wr_addr=5, wr_data=0xDEADBEEF, rd_addr_0=5 → same cycle 0xDEADBEEF with BYPASS_EN, otherwise 0. Next cycle 0xDEADBEEF in both builds. A write to address 0 reads back 0.
- Scoreboard: alloc reg 7 → next cycle rd_ready_0=0 for rd_addr=7. Then write 0x12 to reg 7 → ready returns to 1 the next cycle. Alloc and write reg 9 in the same cycle → data 0x34 stored, ready 0.
- Bulk clear with N=5: fill regs 1..31 with nonzero values, pulse clear_req → clear_busy high for 32 cycles, clear_done pulses once, all reads then return 0 with ready 1. A write issued during CLEAR is lost.
- Reset mid-clear: pulse clear_req, assert rst=0 at clear cycle 10 → clear_busy=0 immediately and no clear_done pulse. A subsequent clear_req runs the full 32 cycles.

Source files
------------

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with busy scoreboard and sequenced bulk clear
// Optional write-to-read forwarding is compiled in when REGFILE_BYPASS_EN is defined.
module regfile_sb #(
  parameter int N  = 5,
  parameter int W  = 32,
  parameter int NR = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NR*N-1:0] rd_addr,
  output logic [NR*W-1:0] rd_data,
  output logic [NR-1:0]   rd_ready,
  input  logic            we,
  input  logic [N-1:0]    wr_addr,
  input  logic [W-1:0]    wr_data,
  input  logic            alloc,
  input  logic [N-1:0]    alloc_addr,
  input  logic            clear_req,
  output logic            clear_busy,
  output logic            clear_done
);

  localparam int DEPTH = 2**N;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t           r_state;
  logic [N-1:0]     r_cnt;
  logic [W-1:0]     r_regs [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic             r_clear_busy;
  logic             r_clear_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_busy       <= '0;
      r_clear_busy <= 1'b0;
      r_clear_done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      r_clear_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (we && wr_addr != '0) begin
            r_regs[wr_addr] <= wr_data;
            r_busy[wr_addr] <= 1'b0;
          end
          // Placed after the write so a same-address alloc leaves the entry busy.
          if (alloc && alloc_addr != '0) r_busy[alloc_addr] <= 1'b1;
          if (clear_req) begin
            r_state      <= S_CLEAR;
            r_cnt        <= '0;
            r_clear_busy <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_regs[r_cnt] <= '0;
          r_busy[r_cnt] <= 1'b0;
          r_cnt         <= r_cnt + N'(1);
          if (r_cnt == N'(DEPTH - 1)) begin
            r_state      <= S_IDLE;
            r_clear_busy <= 1'b0;
            r_clear_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin : read_ports
    logic [N-1:0] ra;
    rd_data  = '0;
    rd_ready = '0;
    ra       = '0;
    for (int k = 0; k < NR; k++) begin
      ra = rd_addr[k*N +: N];
      if (ra == '0) begin
        rd_data[k*W +: W] = '0;
        rd_ready[k]       = 1'b1;
      end else if (r_state == S_CLEAR) begin
        rd_data[k*W +: W] = '0;
        rd_ready[k]       = 1'b0;
`ifdef REGFILE_BYPASS_EN
      end else if (we && wr_addr == ra) begin
        rd_data[k*W +: W] = wr_data;
        rd_ready[k]       = 1'b1;
`endif
      end else begin
        rd_data[k*W +: W] = r_regs[ra];
        rd_ready[k]       = ~r_busy[ra];
      end
    end
  end

  assign clear_busy = r_clear_busy;
  assign clear_done = r_clear_done;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed table-driven bench for regfile_sb
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_ready;
  logic        we = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        alloc = 1'b0;
  logic [4:0]  alloc_addr = '0;
  logic        clear_req = 1'b0;
  logic        clear_busy;
  logic        clear_done;

  int total = 0;
  int bad   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_sb #(.N(5), .W(32), .NR(2)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .alloc(alloc), .alloc_addr(alloc_addr),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        al;
    logic [4:0]  aa;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] d0;
    logic        r0;
    logic [31:0] d1;
    logic        r1;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_port(input string name, input logic [31:0] d0, input logic r0,
                          input logic [31:0] d1, input logic r1);
    chk({name, ".d0"}, rd_data[31:0], d0);
    chk({name, ".r0"}, {31'd0, rd_ready[0]}, {31'd0, r0});
    chk({name, ".d1"}, rd_data[63:32], d1);
    chk({name, ".r1"}, {31'd0, rd_ready[1]}, {31'd0, r1});
  endtask

  task automatic run_clear(input string name, input int wr_at);
    int busy_cnt, done_cnt, done_cyc;
    busy_cnt = 0; done_cnt = 0; done_cyc = 0;
    @(negedge clk);
    clear_req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      clear_req = 1'b0;
      we        = (c == wr_at);
      wr_addr   = 5'd2;
      wr_data   = 32'h0000_0099;
      rd_addr   = {5'd0, 5'd17};
      #1;
      if (clear_busy) busy_cnt++;
      if (clear_done) begin
        done_cnt++;
        done_cyc = c;
        chk({name, ".busy_at_done"}, {31'd0, clear_busy}, 32'd0);
      end
      if (c == 5) chk_port({name, ".read_in_clear"}, 32'd0, 1'b0, 32'd0, 1'b1);
    end
    we = 1'b0;
    chk({name, ".busy_cycles"}, busy_cnt, 32'd32);
    chk({name, ".done_pulses"}, done_cnt, 32'd1);
    chk({name, ".done_cycle"}, done_cyc, 32'd33);
  endtask

  initial begin
    // we, wa, wd, al, aa, ra0, ra1, d0, r0, d1, r1
    vt[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0,
               BYP ? 32'hDEADBEEF : 32'h0, 1'b1, 32'h0, 1'b1};
    vt[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd3, 32'hDEADBEEF, 1'b1, 32'h0, 1'b1};
    vt[2]  = '{1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1};
    vt[3]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0, 32'h0, 1'b1, 32'h0, 1'b1};
    vt[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1};
    vt[5]  = '{1'b1, 5'd7, 32'h12, 1'b0, 5'd0, 5'd7, 5'd0,
               BYP ? 32'h12 : 32'h0, BYP, 32'h0, 1'b1};
    vt[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 32'h12, 1'b1, 32'h0, 1'b1};
    vt[7]  = '{1'b1, 5'd9, 32'h34, 1'b1, 5'd9, 5'd9, 5'd7,
               BYP ? 32'h34 : 32'h0, 1'b1, 32'h12, 1'b1};
    vt[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 32'h34, 1'b0, 32'h0, 1'b1};
    vt[9]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd9, 32'h0, 1'b1, 32'h34, 1'b0};
    vt[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9, 32'h0, 1'b1, 32'h34, 1'b0};
    vt[11] = '{1'b1, 5'd9, 32'h56, 1'b0, 5'd0, 5'd9, 5'd31,
               BYP ? 32'h56 : 32'h34, BYP, 32'h0, 1'b1};
    vt[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd31, 32'h56, 1'b1, 32'h0, 1'b1};

    // Reads while held in reset, then after release.
    for (int a = 1; a < 32; a += 10) begin
      rd_addr = {5'(a), 5'(a)};
      #1;
      chk_port($sformatf("in_reset.a%0d", a), 32'd0, 1'b1, 32'd0, 1'b1);
      #3;
    end
    @(negedge clk);
    rst = 1'b1;
    for (int a = 1; a < 32; a += 10) begin
      @(negedge clk);
      rd_addr = {5'(a), 5'(a)};
      #1;
      chk_port($sformatf("post_reset.a%0d", a), 32'd0, 1'b1, 32'd0, 1'b1);
    end
    chk("post_reset.clear_busy", {31'd0, clear_busy}, 32'd0);
    chk("post_reset.clear_done", {31'd0, clear_done}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      we = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      alloc = vt[i].al; alloc_addr = vt[i].aa;
      rd_addr = {vt[i].ra1, vt[i].ra0};
      #1;
      chk_port($sformatf("vec%0d", i), vt[i].d0, vt[i].r0, vt[i].d1, vt[i].r1);
    end
    @(negedge clk);
    we = 1'b0; alloc = 1'b0;

    // Fill every register, leave two busy, then bulk clear with a write lost mid-clear.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      we = 1'b1; wr_addr = 5'(i); wr_data = 32'h1000_0000 + i;
      alloc = (i == 4 || i == 10); alloc_addr = 5'(i);
    end
    @(negedge clk);
    we = 1'b0; alloc = 1'b0;
    rd_addr = {5'd4, 5'd17};
    #1;
    chk_port("filled", 32'h1000_0011, 1'b1, 32'h1000_0004, 1'b0);
    run_clear("clear", 10);
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      rd_addr = {5'(a), 5'(a)};
      #1;
      chk_port($sformatf("after_clear.a%0d", a), 32'd0, 1'b1, 32'd0, 1'b1);
    end

    // Reset aborts a clear at its tenth cycle; no done pulse follows.
    @(negedge clk);
    clear_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      clear_req = 1'b0;
    end
    #1;
    chk("abort.busy_before", {31'd0, clear_busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort.busy_now", {31'd0, clear_busy}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("abort.done%0d", c), {31'd0, clear_done}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort.done_after_release", {31'd0, clear_done}, 32'd0);
    run_clear("reclear", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
